// File: rtl/wb_write_scheduler_if.sv
// Writeback request bundle from four execution lanes plus the shared
// register-file write port and status outputs of the scheduler.
interface wb_write_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [3:0]          req_valid;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                wr_en;
  logic [3:0]          wr_lane;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                stall;
  logic [3:0]          pending;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_lane, wr_addr, wr_data, stall, pending
  );
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_lane, wr_addr, wr_data, stall, pending
  );
endinterface

// File: rtl/wb_write_scheduler.sv
// Four-lane writeback scheduler: per-lane FIFOs drained round-robin onto a
// single registered register-file write port.
module wb_wsched_lane #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_addr = mem_q[rd_ptr_q].addr;
  assign head_data = mem_q[rd_ptr_q].data;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= '{addr: push_addr, data: push_data};
  end
endmodule

module wb_write_scheduler #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  wb_write_scheduler_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]             full, empty, push, grant;
  logic [NUM_LANES-1:0][ADDR_W-1:0] head_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] head_data;

  logic [1:0]        last_grant_q, last_grant_d, idx;
  logic              found;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        wr_lane_q, wr_lane_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign push[gi] = bus.req_valid[gi] & ~full[gi] & ~flush;

    wb_wsched_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[gi]),
      .pop       (grant[gi]),
      .push_addr (bus.req_addr[gi*ADDR_W +: ADDR_W]),
      .push_data (bus.req_data[gi*DATA_W +: DATA_W]),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head_addr (head_addr[gi]),
      .head_data (head_data[gi])
    );
  end

  assign bus.req_ready = ~full;
  assign bus.pending   = ~empty;
  assign bus.stall     = (|full) | (|(bus.req_valid & full));
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_lane   = wr_lane_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

  // Round-robin: search begins one past the last granted lane; flush keeps history.
  always_comb begin
    grant        = '0;
    found        = 1'b0;
    idx          = '0;
    last_grant_d = last_grant_q;
    if (!flush) begin
      for (int k = 1; k <= NUM_LANES; k++) begin
        idx = last_grant_q + 2'(k);
        if (!found && !empty[idx]) begin
          grant[idx]   = 1'b1;
          last_grant_d = idx;
          found        = 1'b1;
        end
      end
    end
    wr_en_d   = 1'b0;
    wr_lane_d = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (found) begin
      wr_en_d   = 1'b1;
      wr_lane_d = grant;
      wr_addr_d = head_addr[last_grant_d];
      wr_data_d = head_data[last_grant_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 2'd3;
      wr_en_q      <= 1'b0;
      wr_lane_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_lane_q    <= wr_lane_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end
endmodule
